// File: rtl/allegro_codec_pkg.sv
// Shared types for the Allegro codec cfg APB path: bus field types, the
// request bundle held by the guard, and the guard's FSM state encoding.
package allegro_codec_pkg;

    typedef logic [19:0] dcd_targ_cfg_apb_addr_t;
    typedef logic [31:0] dcd_targ_cfg_apb_data_t;
    typedef logic [3:0]  dcd_targ_cfg_apb_strb_t;
    typedef logic [2:0]  dcd_targ_cfg_apb_prot_t;

    localparam int unsigned CODEC_CFG_APB_TIMEOUT_CYCLES = 1024;

    typedef struct packed {
        dcd_targ_cfg_apb_addr_t addr;
        dcd_targ_cfg_apb_data_t data;
        dcd_targ_cfg_apb_strb_t strb;
        dcd_targ_cfg_apb_prot_t prot;
        logic                   write;
    } dcd_targ_cfg_apb_req_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_DECERR = 3'd4,
        ST_DRAIN  = 3'd5
    } allegro_codec_apb_guard_state_e;

endpackage

// File: rtl/allegro_codec_apb_guard.sv
// Terminates fabric APB and re-issues each transfer to the codec cfg target,
// with address-window/alignment decode errors and a downstream response timeout.
module allegro_codec_apb_guard
    import allegro_codec_pkg::*;
#(
    parameter int unsigned WindowBytes   = 32'h0010_0000,
    parameter int unsigned TimeoutCycles = CODEC_CFG_APB_TIMEOUT_CYCLES,
    parameter int unsigned CntW          = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [19:0]     i_s_paddr,
    input  logic [31:0]     i_s_pwdata,
    input  logic [3:0]      i_s_pstrb,
    input  logic [2:0]      i_s_pprot,
    input  logic            i_s_pwrite,
    input  logic            i_s_psel,
    input  logic            i_s_penable,
    output logic            o_s_pready,
    output logic [31:0]     o_s_prdata,
    output logic            o_s_pslverr,
    output logic [19:0]     o_m_paddr,
    output logic [31:0]     o_m_pwdata,
    output logic [3:0]      o_m_pstrb,
    output logic [2:0]      o_m_pprot,
    output logic            o_m_pwrite,
    output logic            o_m_psel,
    output logic            o_m_penable,
    input  logic            i_m_pready,
    input  logic [31:0]     i_m_prdata,
    input  logic            i_m_pslverr,
    input  logic            i_timeout_clr,
    output logic            o_timeout_irq,
    output logic [CntW-1:0] o_timeout_cnt
);

    localparam int unsigned       TimerW      = $clog2(TimeoutCycles) + 1;
    localparam logic [TimerW-1:0] TimerLast   = TimerW'(TimeoutCycles - 1);
    localparam logic [20:0]       WindowLimit = 21'(WindowBytes);
    localparam logic [CntW-1:0]   CntMax      = '1;

    allegro_codec_apb_guard_state_e state_reg, state_next;
    dcd_targ_cfg_apb_req_t          req_reg, req_next;
    logic                           drain_reg, drain_next;
    logic [TimerW-1:0]              timer_reg, timer_next;
    logic [CntW-1:0]                cnt_reg, cnt_next;
    logic                           irq_reg, irq_next;
    logic                           s_pready_reg, s_pready_next;
    logic [31:0]                    s_prdata_reg, s_prdata_next;
    logic                           s_pslverr_reg, s_pslverr_next;
    logic                           m_psel_reg, m_psel_next;
    logic                           m_penable_reg, m_penable_next;
    logic                           timeout_evt;
    logic                           addr_bad;
    logic                           s_start;

    assign addr_bad = ({1'b0, i_s_paddr} >= WindowLimit) || (i_s_paddr[1:0] != 2'b00);
    // A request that arrived while we were busy (e.g. draining) is already in its
    // access phase when we return to IDLE; accept it unless it is just completing.
    assign s_start  = i_s_psel && !(i_s_penable && s_pready_reg);

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        drain_next     = drain_reg;
        timer_next     = timer_reg;
        s_pready_next  = 1'b0;
        s_prdata_next  = '0;
        s_pslverr_next = 1'b0;
        timeout_evt    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s_start) begin
                    req_next = '{addr: i_s_paddr, data: i_s_pwdata, strb: i_s_pstrb,
                                 prot: i_s_pprot, write: i_s_pwrite};
                    state_next = addr_bad ? ST_DECERR : ST_SETUP;
                end
            end
            ST_SETUP: begin
                timer_next = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                timer_next = timer_reg + TimerW'(1);
                if (i_m_pready) begin
                    s_pready_next  = 1'b1;
                    s_prdata_next  = req_reg.write ? '0 : i_m_prdata;
                    s_pslverr_next = i_m_pslverr;
                    state_next     = ST_RESP;
                end else if (timer_reg == TimerLast) begin
                    s_pready_next  = 1'b1;
                    s_pslverr_next = 1'b1;
                    drain_next     = 1'b1;
                    timeout_evt    = 1'b1;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (drain_reg && !i_m_pready) begin
                    state_next = ST_DRAIN;
                end else begin
                    drain_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Late codec data is dropped; only the handshake matters here.
                if (i_m_pready) begin
                    drain_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_DECERR: begin
                s_pready_next  = 1'b1;
                s_pslverr_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        m_psel_next    = (state_next == ST_SETUP) || (state_next == ST_ACCESS) || drain_next;
        m_penable_next = (state_next == ST_ACCESS) || drain_next;
    end

    always_comb begin
        cnt_next = cnt_reg;
        irq_next = irq_reg | timeout_evt;
        if (i_timeout_clr) begin
            cnt_next = timeout_evt ? CntW'(1) : '0;
            irq_next = timeout_evt;
        end else if (timeout_evt && (cnt_reg != CntMax)) begin
            cnt_next = cnt_reg + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            req_reg       <= '0;
            drain_reg     <= 1'b0;
            timer_reg     <= '0;
            cnt_reg       <= '0;
            irq_reg       <= 1'b0;
            s_pready_reg  <= 1'b0;
            s_prdata_reg  <= '0;
            s_pslverr_reg <= 1'b0;
            m_psel_reg    <= 1'b0;
            m_penable_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            drain_reg     <= drain_next;
            timer_reg     <= timer_next;
            cnt_reg       <= cnt_next;
            irq_reg       <= irq_next;
            s_pready_reg  <= s_pready_next;
            s_prdata_reg  <= s_prdata_next;
            s_pslverr_reg <= s_pslverr_next;
            m_psel_reg    <= m_psel_next;
            m_penable_reg <= m_penable_next;
        end
    end

    assign o_s_pready    = s_pready_reg;
    assign o_s_prdata    = s_prdata_reg;
    assign o_s_pslverr   = s_pslverr_reg;
    assign o_m_paddr     = req_reg.addr;
    assign o_m_pwdata    = req_reg.data;
    assign o_m_pstrb     = req_reg.strb;
    assign o_m_pprot     = req_reg.prot;
    assign o_m_pwrite    = req_reg.write;
    assign o_m_psel      = m_psel_reg;
    assign o_m_penable   = m_penable_reg;
    assign o_timeout_irq = irq_reg;
    assign o_timeout_cnt = cnt_reg;

    // The fabric must hold psel through its access phase until we answer.
    upstream_psel_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_s_psel && i_s_penable && !o_s_pready) |=> i_s_psel);

endmodule

// File: tb/tb_allegro_codec_apb_guard.sv
// Directed bench for allegro_codec_apb_guard: forwarded reads/writes, decode
// errors, timeout/drain, counter saturation and clear, and mid-transfer reset.
module tb_allegro_codec_apb_guard;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [19:0] i_s_paddr = '0;
    logic [31:0] i_s_pwdata = '0;
    logic [3:0]  i_s_pstrb = '0;
    logic [2:0]  i_s_pprot = '0;
    logic        i_s_pwrite = 1'b0;
    logic        i_s_psel = 1'b0;
    logic        i_s_penable = 1'b0;
    logic        o_s_pready;
    logic [31:0] o_s_prdata;
    logic        o_s_pslverr;
    logic [19:0] o_m_paddr;
    logic [31:0] o_m_pwdata;
    logic [3:0]  o_m_pstrb;
    logic [2:0]  o_m_pprot;
    logic        o_m_pwrite;
    logic        o_m_psel;
    logic        o_m_penable;
    logic        i_m_pready;
    logic [31:0] i_m_prdata;
    logic        i_m_pslverr;
    logic        i_timeout_clr = 1'b0;
    logic        o_timeout_irq;
    logic [1:0]  o_timeout_cnt;

    allegro_codec_apb_guard #(
        .WindowBytes  (32'h0000_1000),
        .TimeoutCycles(16),
        .CntW         (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_s_paddr    (i_s_paddr),
        .i_s_pwdata   (i_s_pwdata),
        .i_s_pstrb    (i_s_pstrb),
        .i_s_pprot    (i_s_pprot),
        .i_s_pwrite   (i_s_pwrite),
        .i_s_psel     (i_s_psel),
        .i_s_penable  (i_s_penable),
        .o_s_pready   (o_s_pready),
        .o_s_prdata   (o_s_prdata),
        .o_s_pslverr  (o_s_pslverr),
        .o_m_paddr    (o_m_paddr),
        .o_m_pwdata   (o_m_pwdata),
        .o_m_pstrb    (o_m_pstrb),
        .o_m_pprot    (o_m_pprot),
        .o_m_pwrite   (o_m_pwrite),
        .o_m_psel     (o_m_psel),
        .o_m_penable  (o_m_penable),
        .i_m_pready   (i_m_pready),
        .i_m_prdata   (i_m_prdata),
        .i_m_pslverr  (i_m_pslverr),
        .i_timeout_clr(i_timeout_clr),
        .o_timeout_irq(o_timeout_irq),
        .o_timeout_cnt(o_timeout_cnt)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Codec model: fixed wait states, or hung until a manual pready pulse.
    logic        codec_hang = 1'b0;
    logic        codec_pulse = 1'b0;
    int unsigned codec_wait = 0;
    logic [31:0] codec_rdata = '0;
    logic [7:0]  acc_cyc = 8'd0;
    int unsigned m_setups = 0;
    logic [31:0] seen_pwdata = '0;
    logic [3:0]  seen_pstrb = '0;
    logic [19:0] seen_paddr = '0;
    logic        seen_pwrite = 1'b0;

    assign i_m_pready  = o_m_psel && o_m_penable &&
                         (codec_hang ? codec_pulse : (acc_cyc == 8'(codec_wait)));
    assign i_m_prdata  = codec_rdata;
    assign i_m_pslverr = 1'b0;

    always @(posedge i_clk) begin
        if (o_m_psel && o_m_penable && !i_m_pready && !codec_hang) acc_cyc <= acc_cyc + 8'd1;
        else acc_cyc <= 8'd0;
        if (o_m_psel && !o_m_penable) m_setups <= m_setups + 1;
        if (i_m_pready) begin
            seen_pwdata <= o_m_pwdata;
            seen_pstrb  <= o_m_pstrb;
            seen_paddr  <= o_m_paddr;
            seen_pwrite <= o_m_pwrite;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [19:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            input logic wr, output logic [31:0] rdata, output logic err, output int lat);
        int unsigned n;
        bit done;
        @(posedge i_clk); #1;
        i_s_paddr = addr; i_s_pwdata = wdata; i_s_pstrb = strb; i_s_pprot = 3'b010;
        i_s_pwrite = wr; i_s_psel = 1'b1; i_s_penable = 1'b0;
        n = cyc;
        @(posedge i_clk); #1;
        i_s_penable = 1'b1;
        done = 1'b0; rdata = '0; err = 1'b0; lat = -1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge i_clk);
            if (o_s_pready) begin
                done = 1'b1; rdata = o_s_prdata; err = o_s_pslverr; lat = int'(cyc - n);
            end
        end
        if (!done) check_val("xfer_bound", 32'(done), 32'd1);
        $display("xfer addr=%h wr=%0d rdata=%h err=%0d lat=%0d", addr, wr, rdata, err, lat);
        @(posedge i_clk); #1;
        i_s_psel = 1'b0; i_s_penable = 1'b0;
    endtask

    task automatic drain_pulse();
        @(posedge i_clk); #1 codec_pulse = 1'b1;
        @(posedge i_clk); #1 codec_pulse = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int unsigned s0;

        repeat (3) @(posedge i_clk); #1;
        check_val("rst_s_pready", 32'(o_s_pready), 32'd0);
        check_val("rst_m_psel", 32'({o_m_psel, o_m_penable}), 32'd0);
        check_val("rst_cnt_irq", 32'({o_timeout_irq, o_timeout_cnt}), 32'd0);
        check_val("rst_m_paddr", 32'(o_m_paddr), 32'd0);
        i_rst_n = 1'b1;

        // zero-wait read
        codec_rdata = 32'hCAFE_0001; codec_wait = 0; s0 = m_setups;
        apb_xfer(20'h00010, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check_val("rd_lat", 32'(lat), 32'd3);
        check_val("rd_data", rd, 32'hCAFE_0001);
        check_val("rd_err", 32'(er), 32'd0);
        check_val("rd_setups", m_setups - s0, 32'd1);
        check_val("rd_paddr", 32'(seen_paddr), 32'h10);

        // write with 5 codec wait states
        codec_wait = 5; s0 = m_setups;
        apb_xfer(20'h00FFC, 32'h1234_5678, 4'h5, 1'b1, rd, er, lat);
        check_val("wr_lat", 32'(lat), 32'd8);
        check_val("wr_err", 32'(er), 32'd0);
        check_val("wr_rdata", rd, 32'd0);
        check_val("wr_pwdata", seen_pwdata, 32'h1234_5678);
        check_val("wr_pstrb", 32'(seen_pstrb), 32'h5);
        check_val("wr_pwrite", 32'(seen_pwrite), 32'd1);
        check_val("wr_setups", m_setups - s0, 32'd1);

        // decode errors: misaligned, then outside window
        codec_wait = 0; s0 = m_setups;
        apb_xfer(20'h00002, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check_val("mis_lat", 32'(lat), 32'd2);
        check_val("mis_err", 32'(er), 32'd1);
        check_val("mis_rdata", rd, 32'd0);
        apb_xfer(20'h01000, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, er, lat);
        check_val("win_lat", 32'(lat), 32'd2);
        check_val("win_err", 32'(er), 32'd1);
        check_val("dec_setups", m_setups - s0, 32'd0);

        // timeout, drain, and a stalled second request
        codec_hang = 1'b1; codec_rdata = 32'h5A5A_0024; s0 = m_setups;
        apb_xfer(20'h00020, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check_val("to_lat", 32'(lat), 32'd18);
        check_val("to_err", 32'(er), 32'd1);
        check_val("to_rdata", rd, 32'd0);
        check_val("to_irq", 32'(o_timeout_irq), 32'd1);
        check_val("to_cnt", 32'(o_timeout_cnt), 32'd1);
        @(negedge i_clk);
        check_val("drain_m_ctrl", 32'({o_m_psel, o_m_penable, o_s_pready}), 32'b110);
        fork
            apb_xfer(20'h00024, 32'h0, 4'h0, 1'b0, rd, er, lat);
            begin
                repeat (6) @(posedge i_clk);
                #1 codec_pulse = 1'b1;
                @(posedge i_clk);
                #1 codec_pulse = 1'b0; codec_hang = 1'b0;
            end
        join
        check_val("stall_lat", 32'(lat), 32'd9);
        check_val("stall_rdata", rd, 32'h5A5A_0024);
        check_val("stall_err", 32'(er), 32'd0);
        check_val("stall_setups", m_setups - s0, 32'd2);

        // clear, then saturation of the 2-bit counter
        @(posedge i_clk); #1 i_timeout_clr = 1'b1;
        @(posedge i_clk); #1 i_timeout_clr = 1'b0;
        check_val("clr_cnt_irq", 32'({o_timeout_irq, o_timeout_cnt}), 32'd0);
        codec_hang = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            apb_xfer(20'h00040, 32'h0, 4'h0, 1'b0, rd, er, lat);
            check_val($sformatf("sat_cnt_%0d", i), 32'(o_timeout_cnt), (i < 3) ? 32'(i) : 32'd3);
            drain_pulse();
        end
        check_val("sat_irq", 32'(o_timeout_irq), 32'd1);
        fork
            apb_xfer(20'h00044, 32'h0, 4'h0, 1'b0, rd, er, lat);
            begin
                repeat (18) @(posedge i_clk);
                #1 i_timeout_clr = 1'b1;
                @(posedge i_clk);
                #1 i_timeout_clr = 1'b0;
            end
        join
        check_val("clr_evt_lat", 32'(lat), 32'd18);
        check_val("clr_evt_cnt", 32'(o_timeout_cnt), 32'd1);
        check_val("clr_evt_irq", 32'(o_timeout_irq), 32'd1);
        drain_pulse();

        // reset asserted while the downstream access is in progress
        @(posedge i_clk); #1;
        i_s_paddr = 20'h00030; i_s_pwdata = 32'hDEAD_BEEF; i_s_pstrb = 4'hF; i_s_pwrite = 1'b0;
        i_s_psel = 1'b1; i_s_penable = 1'b0;
        @(posedge i_clk); #1 i_s_penable = 1'b1;
        repeat (2) @(posedge i_clk); #1;
        check_val("pre_rst_access", 32'({o_m_psel, o_m_penable}), 32'b11);
        i_rst_n = 1'b0;
        #1;
        check_val("mid_rst_ctrl", 32'({o_s_pready, o_s_pslverr, o_m_psel, o_m_penable,
                                       o_m_pwrite, o_timeout_irq, o_timeout_cnt}), 32'd0);
        check_val("mid_rst_paddr", 32'(o_m_paddr), 32'd0);
        check_val("mid_rst_pwdata", o_m_pwdata, 32'd0);
        check_val("mid_rst_prdata", o_s_prdata, 32'd0);
        i_s_psel = 1'b0; i_s_penable = 1'b0; codec_hang = 1'b0;
        repeat (2) @(posedge i_clk); #1 i_rst_n = 1'b1;
        codec_rdata = 32'h0BAD_F00D;
        apb_xfer(20'h00034, 32'h0, 4'h0, 1'b0, rd, er, lat);
        check_val("post_rst_lat", 32'(lat), 32'd3);
        check_val("post_rst_rdata", rd, 32'h0BAD_F00D);
        check_val("post_rst_err", 32'(er), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, expected summary before it");
        $fatal(1, "watchdog");
    end

endmodule
